// File: rtl/register_file_param.sv
// Purpose : DEPTH x DATA_W register file, NUM_RD async read ports, one sync write port, clear sequencer.
// Latency : reads are combinational; writes land at the accepting edge; a clear takes DEPTH busy cycles plus one done cycle.
// Backpressure: wr_accept_o drops while busy_o is high and the write is discarded (never queued).
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   wr_en_i/addr/data    write request; wr_accept_o = wr_en_i && !busy_o
//   rd_addr_i/rd_data_o  NUM_RD packed read ports, port p at [p*W +: W]
//   clr_req_i            start a clear sequence (sampled only in IDLE)
//   busy_o, clr_done_o   clear in progress / one-cycle completion pulse
//   written_mask_o       bit i set when register i has been written since the last reset/clear
// Optional feature: define REGFILE_WRITE_BYPASS_EN for write-first forwarding to the read ports.
module register_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     wr_accept_o,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     clr_req_i,
  output logic                     busy_o,
  output logic                     clr_done_o,
  output logic [2**ADDR_W-1:0]     written_mask_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    mask_q;
  logic                wr_store;

  assign wr_accept_o    = wr_en_i && !busy_o;
  // An accepted write to the hardwired zero register is acknowledged but has no effect.
  assign wr_store       = wr_accept_o && !((ZERO_REG != 0) && (wr_addr_i == '0));
  assign written_mask_o = mask_q;

  // State register and storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == CLEAR) begin
        mem_q[idx_q[ADDR_W-1:0]]  <= '0;
        mask_q[idx_q[ADDR_W-1:0]] <= 1'b0;
      end else if (wr_store) begin
        mem_q[wr_addr_i]  <= wr_data_i;
        mask_q[wr_addr_i] <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        // idx is one bit wider than the address, so this compare never aliases.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs from state
  always_comb begin
    busy_o     = 1'b0;
    clr_done_o = 1'b0;
    case (state_q)
      CLEAR:   busy_o     = 1'b1;
      DONE:    clr_done_o = 1'b1;
      default: ;
    endcase
  end

  // Read ports
  always_comb begin
    rd_data_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] ra;
      ra = rd_addr_i[p*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data_o[p*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
      end else if (wr_store && (ra == wr_addr_i)) begin
        // Write-first: the value being committed this edge is visible immediately.
        rd_data_o[p*DATA_W +: DATA_W] = wr_data_i;
`endif
      end else begin
        rd_data_o[p*DATA_W +: DATA_W] = mem_q[ra];
      end
    end
  end

endmodule
